fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory in the 3-stage RISC-V pipeline. It owns the PC register and drives the imem word address. It captures the combinational imem instruction into the IF/ID pipeline register with a valid bit. It also handles stall, redirect (branch/jump), the boot bubble, and sticky fetch faults.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_unit_if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the IF/ID register and the fetch unit top.
package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_RANGE    = 2'd2
    } fault_cause_t;

    // Misalignment outranks range when both apply.
    function automatic fault_cause_t pc_cause(
        input logic [1:0] low_bits,
        input logic       out_of_range
    );
        fault_cause_t c;
        c = FC_NONE;
        if (low_bits != 2'b00) begin
            c = FC_MISALIGN;
        end else if (out_of_range) begin
            c = FC_RANGE;
        end
        return c;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold or bubble.
// A bubble always wins over a load in the same cycle.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int AddrWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 bubble,
    input  logic [AddrWidth-1:0] pc_d,
    input  logic [31:0]          instr_d,
    output logic [AddrWidth-1:0] pc_q,
    output logic [31:0]          instr_q,
    output logic                 valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (bubble) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, boot bubble, stall/redirect handling,
// sticky fetch faults and a captured-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   AddrWidth   = 32,
    parameter int                   ImemDepth   = 512,
    parameter logic [AddrWidth-1:0] ResetVector = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [AddrWidth-1:0] redirect_pc_i,
    output logic [AddrWidth-1:0] imem_addr_o,
    input  logic [31:0]          imem_instr_i,
    output logic [AddrWidth-1:0] if_pc_o,
    output logic [31:0]          if_instr_o,
    output logic                 if_valid_o,
    output logic                 fault_o,
    output logic [1:0]           fault_cause_o,
    output logic [31:0]          fetch_count_o
);

    localparam logic [AddrWidth-1:0] ImemLimit =
        AddrWidth'(ImemDepth * 4);

    fetch_state_t         state_q, state_d;
    fault_cause_t         cause_q, cause_d;
    fault_cause_t         pc_chk;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [31:0]          count_q, count_d;
    logic                 fault_q, fault_d;
    logic                 ifid_load;
    logic                 ifid_bubble;

    assign pc_chk = pc_cause(pc_q[1:0], pc_q >= ImemLimit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= ResetVector;
            count_q <= '0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    pc_d        = redirect_pc_i;
                    ifid_bubble = 1'b1;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (pc_chk != FC_NONE) begin
                    state_d     = FAULT;
                    fault_d     = 1'b1;
                    cause_d     = pc_chk;
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + AddrWidth'(4);
                    count_d   = count_q + 32'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    if_id_reg #(
        .AddrWidth(AddrWidth)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .pc_d    (pc_q),
        .instr_d (imem_instr_i),
        .pc_q    (if_pc_o),
        .instr_q (if_instr_o),
        .valid_q (if_valid_o)
    );

    assign imem_addr_o   = pc_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a capture scoreboard.
// Expected values are hand-derived per row.
module tb_fetch_unit;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] fetch_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic [31:0] e_count;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } cap_t;

    cap_t        sb[$];
    logic [31:0] last_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [8:0] idx);
        if (idx == 9'd0) return 32'hAAAA_0001;
        if (idx == 9'd1) return 32'hBBBB_0002;
        return {16'hD0D0, 7'd0, idx};
    endfunction

    assign imem_instr_i = wd(imem_addr_o[10:2]);

    fetch_unit #(
        .AddrWidth  (32),
        .ImemDepth  (512),
        .ResetVector(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_valid_o    (if_valid_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .fetch_count_o (fetch_count_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input logic rd, input logic [31:0] rpc,
        input logic v, input logic [31:0] ifpc, input logic [31:0] ins,
        input logic [31:0] pc, input logic f, input logic [1:0] c,
        input logic [31:0] cnt);
        vec_t r;
        r.stall = st;  r.redir = rd;    r.rpc = rpc;
        r.e_valid = v; r.e_ifpc = ifpc; r.e_instr = ins;
        r.e_pc = pc;   r.e_fault = f;   r.e_cause = c;
        r.e_count = cnt;
        return r;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, imem_addr_o, 32'h0);
        chk({tag, "_ifpc"}, if_pc_o, 32'h0);
        chk({tag, "_instr"}, if_instr_o, NOPW);
        chk({tag, "_valid"}, 32'(if_valid_o), 32'h0);
        chk({tag, "_fault"}, 32'(fault_o), 32'h0);
        chk({tag, "_cause"}, 32'(fault_cause_o), 32'h0);
        chk({tag, "_count"}, fetch_count_o, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        @(posedge clk);
        #1;
        check_reset("rst");
        sb.delete();
        last_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one row, push expected capture, clock, compare.
    task automatic run_row(input string tag, input int i, input vec_t v,
                           input logic [31:0] prev_pc,
                           input logic [31:0] prev_cnt);
        string nm;
        cap_t  e;
        cap_t  got;
        stall_i = v.stall;
        redirect_i = v.redir;
        redirect_pc_i = v.rpc;
        if (v.e_count != prev_cnt) begin
            e.pc = prev_pc;
            e.instr = wd(prev_pc[10:2]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        nm = $sformatf("%s%0d", tag, i);
        chk({nm, "_valid"}, 32'(if_valid_o), 32'(v.e_valid));
        chk({nm, "_ifpc"}, if_pc_o, v.e_ifpc);
        chk({nm, "_instr"}, if_instr_o, v.e_instr);
        chk({nm, "_pc"}, imem_addr_o, v.e_pc);
        chk({nm, "_fault"}, 32'(fault_o), 32'(v.e_fault));
        chk({nm, "_cause"}, 32'(fault_cause_o), 32'(v.e_cause));
        chk({nm, "_count"}, fetch_count_o, v.e_count);
        if (fetch_count_o !== last_cnt) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_sb: unexpected capture pc %h", nm, if_pc_o);
            end else begin
                got = sb.pop_front();
                chk({nm, "_sb_pc"}, if_pc_o, got.pc);
                chk({nm, "_sb_instr"}, if_instr_o, got.instr);
            end
            last_cnt = fetch_count_o;
        end
    endtask

    task automatic run_tab(input string tag, input vec_t t[$]);
        logic [31:0] ppc;
        logic [31:0] pcnt;
        ppc = 32'h0;
        pcnt = 32'h0;
        for (int i = 0; i < t.size(); i++) begin
            run_row(tag, i, t[i], ppc, pcnt);
            ppc = t[i].e_pc;
            pcnt = t[i].e_count;
        end
    endtask

    initial begin
        vec_t ta[$];
        vec_t tb[$];
        vec_t tc[$];

        // Main run: boot, capture, stall, redirect+stall, range fault.
        ta.push_back(mk(0,0,0, 0,0,NOPW, 32'h0,0,0,0));
        ta.push_back(mk(0,0,0, 1,0,32'hAAAA_0001, 32'h4,0,0,1));
        ta.push_back(mk(0,0,0, 1,4,32'hBBBB_0002, 32'h8,0,0,2));
        ta.push_back(mk(1,0,0, 1,4,32'hBBBB_0002, 32'h8,0,0,2));
        ta.push_back(mk(1,0,0, 1,4,32'hBBBB_0002, 32'h8,0,0,2));
        ta.push_back(mk(1,0,0, 1,4,32'hBBBB_0002, 32'h8,0,0,2));
        ta.push_back(mk(0,0,0, 1,8,32'hD0D0_0002, 32'hC,0,0,3));
        ta.push_back(mk(1,1,32'h40, 0,0,NOPW, 32'h40,0,0,3));
        ta.push_back(mk(0,0,0, 1,32'h40,32'hD0D0_0010, 32'h44,0,0,4));
        ta.push_back(mk(0,1,32'h7F8, 0,0,NOPW, 32'h7F8,0,0,4));
        ta.push_back(mk(0,0,0, 1,32'h7F8,32'hD0D0_01FE, 32'h7FC,0,0,5));
        ta.push_back(mk(0,0,0, 1,32'h7FC,32'hD0D0_01FF, 32'h800,0,0,6));
        ta.push_back(mk(0,0,0, 0,0,NOPW, 32'h800,1,2,6));
        ta.push_back(mk(0,1,32'h0, 0,0,NOPW, 32'h800,1,2,6));

        // Misaligned redirect, stalled first, then ignored redirects.
        tb.push_back(mk(0,0,0, 0,0,NOPW, 32'h0,0,0,0));
        tb.push_back(mk(0,0,0, 1,0,32'hAAAA_0001, 32'h4,0,0,1));
        tb.push_back(mk(0,1,32'h42, 0,0,NOPW, 32'h42,0,0,1));
        tb.push_back(mk(1,0,0, 0,0,NOPW, 32'h42,0,0,1));
        tb.push_back(mk(0,0,0, 0,0,NOPW, 32'h42,1,1,1));
        tb.push_back(mk(0,1,32'h0, 0,0,NOPW, 32'h42,1,1,1));
        tb.push_back(mk(1,1,32'h10, 0,0,NOPW, 32'h42,1,1,1));

        // Misaligned and out of range together: misalign wins.
        tc.push_back(mk(0,0,0, 0,0,NOPW, 32'h0,0,0,0));
        tc.push_back(mk(0,1,32'h802, 0,0,NOPW, 32'h802,0,0,0));
        tc.push_back(mk(0,0,0, 0,0,NOPW, 32'h802,1,1,0));

        last_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        @(negedge clk);
        rst_n = 1'b1;
        run_tab("a", ta);

        do_reset();
        run_tab("b", tb);

        // Asynchronous reset mid-cycle while faulted.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        chk("async_noedge", 32'(clk), 32'h0);
        sb.delete();
        last_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_tab("c", tc);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
